sseg_scan4: RTL and testbench

SSEG_SCAN4 -- requirements
Module: sseg_scan4

---
 rtl/sseg_pkg.sv | 28 ++
 rtl/hex_to_sseg.sv | 11 +
 rtl/sseg_scan4.sv | 110 +++++++++++
 tb/tb_sseg_scan4.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared definitions for the 4-digit seven-segment scanner: digit index type,
// blank pattern and the active-low {g,f,e,d,c,b,a} hex glyph table.
package sseg_pkg;

   typedef logic [1:0] digit_idx_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [6:0] SEG_TABLE [16] = '{
      7'b1000000,  // 0
      7'b1111001,  // 1
      7'b0100100,  // 2
      7'b0110000,  // 3
      7'b0011001,  // 4
      7'b0010010,  // 5
      7'b0000010,  // 6
      7'b1111000,  // 7
      7'b0000000,  // 8
      7'b0010000,  // 9
      7'b0001000,  // A
      7'b0000011,  // b
      7'b1000110,  // C
      7'b0100001,  // d
      7'b0000110,  // E
      7'b0001110   // F
   };

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational hex nibble to active-low seven-segment glyph lookup.
module hex_to_sseg
   import sseg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/sseg_scan4.sv
// Four-digit multiplexed seven-segment scanner with double-buffered value/dp.
// Optional leading-zero blanking is enabled by defining SSEG_LZB_EN.
module sseg_scan4
   import sseg_pkg::*;
#(
   parameter int unsigned DIV = 100000
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] value,
   input  logic [3:0]  dp_in,
   input  logic        load,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_done
);

   localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

   logic [PW-1:0] presc;
   digit_idx_t    idx;
   logic [15:0]   pend_val;
   logic [3:0]    pend_dp;
   logic [15:0]   shad_val;
   logic [3:0]    shad_dp;
   logic          tick;
   logic          boundary;
   logic [3:0]    nibble;
   logic [6:0]    seg_dec;
   logic          blank;

   assign tick     = (presc == PMAX);
   assign boundary = tick && (idx == digit_idx_t'(3));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc <= '0;
         idx   <= '0;
      end else begin
         presc <= tick ? '0 : presc + 1'b1;
         if (tick)
            idx <= idx + digit_idx_t'(1);
      end
   end

   // A load landing on the boundary cycle bypasses pending so it shows next frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_val <= '0;
         pend_dp  <= '0;
         shad_val <= '0;
         shad_dp  <= '0;
      end else begin
         if (load) begin
            pend_val <= value;
            pend_dp  <= dp_in;
         end
         if (boundary) begin
            shad_val <= load ? value : pend_val;
            shad_dp  <= load ? dp_in : pend_dp;
         end
      end
   end

   assign nibble = shad_val[{idx, 2'b00} +: 4];

   hex_to_sseg u_dec (
      .nibble (nibble),
      .seg    (seg_dec)
   );

`ifdef SSEG_LZB_EN
   // A dp request on this or any higher digit ends the run of leading zeros.
   always_comb begin
      blank = 1'b0;
      case (idx)
         2'd3:    blank = (shad_val[15:12] == 4'h0)  && (shad_dp[3:3] == 1'b0);
         2'd2:    blank = (shad_val[15:8]  == 8'h00) && (shad_dp[3:2] == 2'b00);
         2'd1:    blank = (shad_val[15:4]  == 12'h000) && (shad_dp[3:1] == 3'b000);
         default: blank = 1'b0;
      endcase
   end
`else
   assign blank = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an         <= 4'b1111;
         seg        <= SEG_BLANK;
         dp         <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         frame_done <= boundary;
         if (blank) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
         end else begin
            an  <= ~(4'b0001 << idx);
            seg <= seg_dec;
            dp  <= ~shad_dp[idx];
         end
      end
   end

endmodule

// File: tb/tb_sseg_scan4.sv
// Scoreboard bench for sseg_scan4: DIV=4 and DIV=1 instances share stimulus and
// are compared each cycle against an arithmetic model of the scan sequence.
`timescale 1ns/1ps
module tb_sseg_scan4;

   logic        clk = 1'b0;
   logic        rst;
   logic        load;
   logic [15:0] value;
   logic [3:0]  dp_in;

   logic [3:0]  an4, an1;
   logic [6:0]  seg4, seg1;
   logic        dp4, dp1, fd4, fd1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sseg_scan4 #(.DIV(4)) dut4 (
      .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
      .an(an4), .seg(seg4), .dp(dp4), .frame_done(fd4)
   );

   sseg_scan4 #(.DIV(1)) dut1 (
      .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
      .an(an1), .seg(seg1), .dp(dp1), .frame_done(fd1)
   );

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       fd;
   } out_t;

   typedef struct packed {
      logic [31:0] cyc;
      out_t        d4;
      out_t        d1;
   } exp_t;

   exp_t exp_q[$];

   // Reference model state: edges since reset release, per-instance buffers
   int          m;
   int          divs [2] = '{4, 1};
   logic [15:0] sh_v [2];
   logic [3:0]  sh_d [2];
   logic [15:0] pd_v [2];
   logic [3:0]  pd_d [2];

   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: return 7'b1000000;
         4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;
         4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;
         4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;
         4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;
         4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;
         4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;
         default: return 7'b0001110;
      endcase
   endfunction

   // Output after edge m shows the digit selected during the preceding cycle.
   function automatic out_t predict(input int k, input int mm);
      out_t        o;
      int          idx;
      logic [15:0] sv;
      logic [3:0]  sd;
      logic        blank;
      idx   = ((mm - 1) / divs[k]) % 4;
      sv    = sh_v[k] >> (4 * idx);
      sd    = sh_d[k] >> idx;
      blank = 1'b0;
`ifdef SSEG_LZB_EN
      blank = (idx != 0) && (sv == 16'h0) && (sd == 4'h0);
`endif
      if (blank) begin
         o.an  = 4'b1111;
         o.seg = 7'b1111111;
         o.dp  = 1'b1;
      end else begin
         o.an  = ~(4'b0001 << idx);
         o.seg = glyph(sv[3:0]);
         o.dp  = ~sh_d[k][idx];
      end
      o.fd = ((mm % (4 * divs[k])) == 0);
      return o;
   endfunction

   task automatic model_reset();
      m = 0;
      for (int k = 0; k < 2; k++) begin
         sh_v[k] = '0; sh_d[k] = '0; pd_v[k] = '0; pd_d[k] = '0;
      end
   endtask

   task automatic model_edge(input logic ld, input logic [15:0] v, input logic [3:0] d);
      exp_t e;
      m++;
      e.cyc = 32'(m);
      e.d4  = predict(0, m);
      e.d1  = predict(1, m);
      exp_q.push_back(e);
      for (int k = 0; k < 2; k++) begin
         if ((m % (4 * divs[k])) == 0) begin
            sh_v[k] = ld ? v : pd_v[k];
            sh_d[k] = ld ? d : pd_d[k];
         end
         if (ld) begin
            pd_v[k] = v;
            pd_d[k] = d;
         end
      end
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, expv, $time);
      end
   endtask

   task automatic chk_reset_outputs();
      chk("rst_an4",  16'(an4),  16'hF);
      chk("rst_seg4", 16'(seg4), 16'h7F);
      chk("rst_dp4",  16'(dp4),  16'h1);
      chk("rst_fd4",  16'(fd4),  16'h0);
      chk("rst_an1",  16'(an1),  16'hF);
      chk("rst_seg1", 16'(seg1), 16'h7F);
      chk("rst_dp1",  16'(dp1),  16'h1);
      chk("rst_fd1",  16'(fd1),  16'h0);
   endtask

   // Inputs are applied 1ns after an edge and take effect at the next edge.
   task automatic cycle(input logic ld, input logic [15:0] v, input logic [3:0] d);
      load  = ld;
      value = v;
      dp_in = d;
      @(posedge clk);
      #1;
      model_edge(ld, v, d);
      load = 1'b0;
   endtask

   // Asynchronous reset asserted between clock edges, checked before any edge.
   task automatic mid_reset();
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk_reset_outputs();
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs();
      rst = 1'b0;
      model_reset();
   endtask

   task automatic run_random(input int n);
      logic [15:0] v;
      for (int i = 0; i < n; i++) begin
         v = 16'($urandom);
         case ($urandom_range(3, 0))
            0: v = v & 16'h000F;
            1: v = v & 16'h00FF;
            default: ;
         endcase
         cycle($urandom_range(9, 0) == 0, v, 4'($urandom));
      end
   endtask

   // Monitor: compares one queued expectation per cycle on the falling edge
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if ({an4, seg4, dp4, fd4} !== e.d4)
               $display("cycle %0d (DIV=4)", e.cyc);
            chk("an_div4",  16'(an4),  16'(e.d4.an));
            chk("seg_div4", 16'(seg4), 16'(e.d4.seg));
            chk("dp_div4",  16'(dp4),  16'(e.d4.dp));
            chk("fd_div4",  16'(fd4),  16'(e.d4.fd));
            chk("an_div1",  16'(an1),  16'(e.d1.an));
            chk("seg_div1", 16'(seg1), 16'(e.d1.seg));
            chk("dp_div1",  16'(dp1),  16'(e.d1.dp));
            chk("fd_div1",  16'(fd1),  16'(e.d1.fd));
         end
      end
   end

   initial begin
      load  = 1'b0;
      value = '0;
      dp_in = '0;
      rst   = 1'b0;
      #1 rst = 1'b1;
      #1 chk_reset_outputs();
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();

      // 1234 loaded right after reset, shown from the second frame on
      cycle(1'b1, 16'h1234, 4'b0000);
      repeat (47) cycle(1'b0, 16'hFFFF, 4'hF);

      // 00A5 loaded mid-frame: old digits persist until the frame end
      while ((m % 16) != 5) cycle(1'b0, 16'h0, 4'h0);
      cycle(1'b1, 16'h00A5, 4'b0001);
      repeat (36) cycle(1'b0, 16'h1111, 4'h0);

      // load coinciding with the boundary edge goes straight to shadow
      while (((m + 1) % 16) != 0) cycle(1'b0, 16'h0, 4'h0);
      cycle(1'b1, 16'hBEEF, 4'b1010);
      repeat (20) cycle(1'b0, 16'h0, 4'h0);

      // small values for leading-zero handling, with and without dp requests
      cycle(1'b1, 16'h0007, 4'b0000);
      repeat (40) cycle(1'b0, 16'h0, 4'h0);
      cycle(1'b1, 16'h0007, 4'b0100);
      repeat (40) cycle(1'b0, 16'h0, 4'h0);
      cycle(1'b1, 16'h0000, 4'b0000);
      repeat (36) cycle(1'b0, 16'h0, 4'h0);

      // reset mid-frame discards both pending and shadow
      cycle(1'b1, 16'h9876, 4'b1111);
      repeat (6) cycle(1'b0, 16'h0, 4'h0);
      mid_reset();
      repeat (40) cycle(1'b0, 16'h0, 4'h0);

      run_random(700);
      mid_reset();
      run_random(400);

      @(negedge clk);
      #1;
      chk("queue_drained", 16'(exp_q.size()), 16'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
